// File: rtl/sid_filter_sched.sv
// sid_filter_sched: time-multiplexes one sid_filter pipeline
// across up to N_SID SID instances, eight cycles per instance.
module sid_filter_sched #(
    parameter int N_SID = 2,
    parameter int SEL_W = (N_SID > 1) ? $clog2(N_SID) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic [3:0]       n_active,
    input  logic             clr_overrun,
    output logic [2:0]       stage,
    output logic [SEL_W-1:0] sel,
    output logic             state_we,
    output logic             audio_valid,
    output logic             busy,
    output logic             overrun
);

    typedef enum logic {
        S_IDLE,
        S_RUN
    } state_t;

    state_t           r_state;
    logic [2:0]       r_k;
    logic [SEL_W-1:0] r_sel;
    logic [SEL_W-1:0] r_last;
    logic [2:0]       r_stage;
    logic             r_state_we;
    logic             r_audio_valid;
    logic             r_overrun;

    logic [3:0]       w_n_eff;
    logic [3:0]       w_n_last;
    logic             w_last_gap;
    logic             w_accept;
    logic             w_reject;

    // Clamp the requested instance count into 1..N_SID
    always_comb begin
        w_n_eff = n_active;
        if (n_active == 4'd0) begin
            w_n_eff = 4'd1;
        end else if (n_active > 4'(N_SID)) begin
            w_n_eff = 4'(N_SID);
        end
        w_n_last = w_n_eff - 4'd1;
    end

    // A tick is taken in IDLE or in the gap slot of the last instance
    assign w_last_gap = (r_state == S_RUN) && (r_k == 3'd7)
                        && (r_sel == r_last);
    assign w_accept   = tick && ((r_state == S_IDLE) || w_last_gap);
    assign w_reject   = tick && !w_accept;

    // Sequencer FSM with registered stage/strobe outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_k           <= 3'd0;
            r_sel         <= '0;
            r_last        <= '0;
            r_stage       <= 3'd0;
            r_state_we    <= 1'b0;
            r_audio_valid <= 1'b0;
        end else if (w_accept) begin
            r_state       <= S_RUN;
            r_k           <= 3'd0;
            r_sel         <= '0;
            r_last        <= w_n_last[SEL_W-1:0];
            r_stage       <= 3'd1;
            r_state_we    <= 1'b0;
            r_audio_valid <= 1'b0;
        end else if (r_state == S_RUN) begin
            if (r_k == 3'd7) begin
                r_k           <= 3'd0;
                r_state_we    <= 1'b0;
                r_audio_valid <= 1'b0;
                if (r_sel == r_last) begin
                    r_state <= S_IDLE;
                    r_sel   <= '0;
                    r_stage <= 3'd0;
                end else begin
                    r_sel   <= r_sel + 1'b1;
                    r_stage <= 3'd1;
                end
            end else begin
                r_k           <= r_k + 3'd1;
                r_stage       <= (r_k == 3'd6) ? 3'd0 : r_k + 3'd2;
                r_state_we    <= (r_k == 3'd5);
                r_audio_valid <= (r_k == 3'd6);
            end
        end
    end

    // Sticky overrun; a rejected tick beats a clear
    always_ff @(posedge clk) begin
        if (rst) begin
            r_overrun <= 1'b0;
        end else if (w_reject) begin
            r_overrun <= 1'b1;
        end else if (clr_overrun) begin
            r_overrun <= 1'b0;
        end
    end

    assign stage       = r_stage;
    assign sel         = r_sel;
    assign state_we    = r_state_we;
    assign audio_valid = r_audio_valid;
    assign busy        = (r_state == S_RUN);
    assign overrun     = r_overrun;

endmodule

// File: tb/tb_sid_filter_sched.sv
// tb_sid_filter_sched: directed and random ticks checked against
// a schedule model that tracks position within the whole sequence.
module tb_sid_filter_sched;

    localparam int N_SID = 2;
    localparam int SEL_W = 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             tick = 1'b0;
    logic [3:0]       n_active = 4'd0;
    logic             clr_overrun = 1'b0;
    logic [2:0]       stage;
    logic [SEL_W-1:0] sel;
    logic             state_we;
    logic             audio_valid;
    logic             busy;
    logic             overrun;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;

    // model: m_pos = cycle index inside the sequence, -1 when idle
    int m_pos = -1;
    int m_neff = 1;
    bit m_ovr = 1'b0;

    sid_filter_sched #(.N_SID(N_SID)) dut (
        .clk(clk),
        .rst(rst),
        .tick(tick),
        .n_active(n_active),
        .clr_overrun(clr_overrun),
        .stage(stage),
        .sel(sel),
        .state_we(state_we),
        .audio_valid(audio_valid),
        .busy(busy),
        .overrun(overrun)
    );

    always #5 clk = ~clk;

    function automatic int clampn(input int n);
        if (n < 1) return 1;
        if (n > N_SID) return N_SID;
        return n;
    endfunction

    task automatic model_edge(input bit t, input int n,
                              input bit c, input bit r);
        bit acc;
        if (r) begin
            m_pos = -1;
            m_ovr = 1'b0;
        end else begin
            acc = t && (m_pos == -1 || m_pos == 8 * m_neff - 1);
            if (t && !acc) m_ovr = 1'b1;
            else if (c) m_ovr = 1'b0;
            if (acc) begin
                m_pos = 0;
                m_neff = clampn(n);
            end else if (m_pos >= 0) begin
                m_pos = m_pos + 1;
                if (m_pos == 8 * m_neff) m_pos = -1;
            end
        end
    endtask

    task automatic chk1(input string tag, input int obs, input int exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s cyc=%0d observed=%0d expected=%0d",
                   tag, cyc, obs, exp_v);
        end
    endtask

    task automatic check_all();
        int e_stage, e_sel, e_we, e_av, e_busy, slot;
        e_stage = 0; e_sel = 0; e_we = 0; e_av = 0; e_busy = 0;
        if (m_pos >= 0) begin
            slot = m_pos % 8;
            e_sel = m_pos / 8;
            e_stage = (slot < 7) ? slot + 1 : 0;
            e_we = (slot == 6);
            e_av = (slot == 7);
            e_busy = 1;
        end
        chk1("stage", int'(stage), e_stage);
        chk1("sel", int'(sel), e_sel);
        chk1("state_we", int'(state_we), e_we);
        chk1("audio_valid", int'(audio_valid), e_av);
        chk1("busy", int'(busy), e_busy);
        chk1("overrun", int'(overrun), int'(m_ovr));
    endtask

    task automatic step(input bit t, input int n,
                        input bit c, input bit r);
        @(negedge clk);
        tick = t;
        n_active = 4'(n);
        clr_overrun = c;
        rst = r;
        @(posedge clk);
        cyc++;
        model_edge(t, n, c, r);
        #1;
        check_all();
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) step(0, 2, 0, 0);
    endtask

    initial begin
        int seen_any;
        // reset and idle up to the tick in cycle 10
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        step(0, 0, 0, 0);
        idle(6);
        step(1, 2, 0, 0);
        idle(20);
        // clamping: 0 -> one instance, 9 -> N_SID instances
        step(1, 0, 0, 0);
        idle(12);
        step(1, 9, 0, 0);
        idle(20);
        // rejected tick at T+5, clear at T+20
        step(1, 2, 0, 0);
        idle(4);
        step(1, 2, 0, 0);
        idle(14);
        step(0, 2, 1, 0);
        idle(4);
        // back-to-back tick in the final gap slot
        step(1, 2, 0, 0);
        idle(15);
        step(1, 2, 0, 0);
        idle(20);
        // reset during instance 0, then clean restart
        step(1, 2, 0, 0);
        idle(3);
        seen_any = 0;
        step(0, 2, 0, 1);
        for (int i = 0; i < 10; i++) begin
            step(0, 2, 0, 0);
            if (state_we || audio_valid) seen_any = 1;
        end
        chk1("abort_strobe", seen_any, 0);
        step(1, 2, 0, 0);
        idle(18);
        // tick with reset is ignored
        step(1, 2, 0, 1);
        idle(3);
        // rejected tick coinciding with clear
        step(1, 2, 0, 0);
        idle(2);
        step(1, 2, 1, 0);
        idle(16);
        // random traffic
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 9) == 0),
                 int'($urandom_range(0, 15)),
                 ($urandom_range(0, 15) == 0),
                 ($urandom_range(0, 199) == 0));
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
